// File: rtl/vga_text_pkg.sv
// Shared constants, FSM state type and address helpers for the VGA text buffer.
package vga_text_pkg;

    localparam logic [15:0] CH_LF        = 16'h000A;
    localparam logic [15:0] CH_CR        = 16'h000D;
    localparam logic [15:0] CH_BS        = 16'h0008;
    localparam logic [15:0] CH_FF        = 16'h000C;
    localparam logic [15:0] BLANK_CODE   = 16'h0020;
    localparam logic [15:0] CURSOR_GLYPH = 16'h005F;
    localparam int          CELL_PX      = 16;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Row sums never exceed 2*ROWS-2, so a single compare-and-subtract is a full modulo.
    function automatic logic [4:0] wrap_row(input logic [5:0] sum, input int rows);
        if (sum >= 6'(rows)) begin
            return 5'(sum - 6'(rows));
        end else begin
            return 5'(sum);
        end
    endfunction

    function automatic logic [9:0] cell_addr(input logic [4:0] phys, input logic [5:0] col,
                                             input int cols);
        return (10'(phys) * 10'(cols)) + 10'(col);
    endfunction

endpackage

// File: rtl/vga_text_ram.sv
// Simple dual-port character RAM: one synchronous write port, one registered read-first read port.
module vga_text_ram #(
    parameter int DEPTH = 1000
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [9:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [9:0]  i_raddr,
    output logic [15:0] o_rdata
);

    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_rdata;

    // Write port and registered read; a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_text_buffer.sv
// Terminal-style text frame buffer with hardware scroll; cursor blink when CURSOR_BLINK_EN is defined.
module vga_text_buffer
    import vga_text_pkg::*;
#(
    parameter int          COLS  = 40,
    parameter int          ROWS  = 25,
    parameter logic [15:0] BLANK = BLANK_CODE
`ifdef CURSOR_BLINK_EN
    ,
    parameter int          BLINK_CYCLES = 25_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        putc_valid,
    output logic        putc_ready,
    input  logic [15:0] putc_char,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    output logic [15:0] zb_code,
    output logic [5:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_cnt, w_cnt_nxt;
    logic [9:0]  r_clr_base, w_clr_base_nxt;
    logic [5:0]  r_col, w_col_nxt;
    logic [4:0]  r_row, w_row_nxt;
    logic [4:0]  r_top, w_top_nxt;
    logic        r_ready, r_busy;
    logic        w_newline, w_we;
    logic [9:0]  w_waddr, w_raddr;
    logic [15:0] w_wdata, w_rd_data;
    logic [4:0]  w_cur_phys, w_rd_phys, w_disp_row;
    logic [5:0]  w_cell_col;
    logic        w_in_area, r_rd_blank;

    assign w_cur_phys = wrap_row({1'b0, r_row} + {1'b0, r_top}, ROWS);

    // Next-state, cursor, scroll and write-port decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_top_nxt      = r_top;
        w_clr_base_nxt = r_clr_base;
        w_we           = 1'b0;
        w_waddr        = 10'd0;
        w_wdata        = BLANK;
        w_newline      = 1'b0;
        case (r_state)
            INIT: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                if (r_cnt == 10'(COLS * ROWS - 1)) begin
                    w_cnt_nxt   = 10'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_base + r_cnt;
                if (r_cnt == 10'(COLS - 1)) begin
                    w_cnt_nxt   = 10'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            IDLE: begin
                if (putc_valid) begin
                    case (putc_char)
                        CH_LF: begin
                            w_col_nxt = 6'd0;
                            w_newline = 1'b1;
                        end
                        CH_CR: begin
                            w_col_nxt = 6'd0;
                        end
                        CH_BS: begin
                            if (r_col != 6'd0) begin
                                w_col_nxt = r_col - 6'd1;
                                w_we      = 1'b1;
                                w_waddr   = cell_addr(w_cur_phys, r_col - 6'd1, COLS);
                            end else begin
                                w_col_nxt = r_col;
                            end
                        end
                        CH_FF: begin
                            w_col_nxt   = 6'd0;
                            w_row_nxt   = 5'd0;
                            w_top_nxt   = 5'd0;
                            w_cnt_nxt   = 10'd0;
                            w_state_nxt = INIT;
                        end
                        default: begin
                            w_we    = 1'b1;
                            w_waddr = cell_addr(w_cur_phys, r_col, COLS);
                            w_wdata = putc_char;
                            if (r_col < 6'(COLS - 1)) begin
                                w_col_nxt = r_col + 6'd1;
                            end else begin
                                w_col_nxt = 6'd0;
                                w_newline = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_cnt_nxt   = 10'd0;
            end
        endcase
        // Scrolling retires the current top row, which becomes the new bottom to be blanked.
        if (w_newline) begin
            if (r_row < 5'(ROWS - 1)) begin
                w_row_nxt = r_row + 5'd1;
            end else begin
                w_top_nxt      = (r_top == 5'(ROWS - 1)) ? 5'd0 : r_top + 5'd1;
                w_clr_base_nxt = cell_addr(r_top, 6'd0, COLS);
                w_cnt_nxt      = 10'd0;
                w_state_nxt    = CLEAR;
            end
        end else begin
            w_row_nxt = w_row_nxt;
        end
    end

    // State, cursor and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT;
            r_cnt      <= 10'd0;
            r_clr_base <= 10'd0;
            r_col      <= 6'd0;
            r_row      <= 5'd0;
            r_top      <= 5'd0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clr_base <= w_clr_base_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_top      <= w_top_nxt;
            r_ready    <= (w_state_nxt == IDLE);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign w_cell_col = xpos[9:4];
    assign w_disp_row = ypos[8:4];
    assign w_in_area  = (xpos < 10'(COLS * CELL_PX)) && (ypos < 10'(ROWS * CELL_PX));
    assign w_rd_phys  = wrap_row({1'b0, w_disp_row} + {1'b0, r_top}, ROWS);
    assign w_raddr    = w_in_area ? cell_addr(w_rd_phys, w_cell_col, COLS) : 10'd0;

    vga_text_ram #(
        .DEPTH(COLS * ROWS)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(w_raddr),
        .o_rdata(w_rd_data)
    );

    // Off-screen flag aligned with the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_blank <= 1'b1;
        end else begin
            r_rd_blank <= !w_in_area;
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [31:0] r_blink_cnt;
    logic        r_blink_on, r_rd_cursor, w_at_cursor;

    assign w_at_cursor = w_in_area && (r_state == IDLE) && (w_disp_row == r_row) && (w_cell_col == r_col);

    // Free-running half-period counter for the cursor glyph.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= 32'd0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == 32'(BLINK_CYCLES - 1)) begin
            r_blink_cnt <= 32'd0;
            r_blink_on  <= !r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
        end
    end

    // Cursor overlay flag aligned with the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cursor <= 1'b0;
        end else begin
            r_rd_cursor <= w_at_cursor && r_blink_on;
        end
    end

    assign zb_code = r_rd_blank ? BLANK : (r_rd_cursor ? CURSOR_GLYPH : w_rd_data);
`else
    assign zb_code = r_rd_blank ? BLANK : w_rd_data;
`endif

    assign putc_ready = r_ready;
    assign busy       = r_busy;
    assign cur_col    = r_col;
    assign cur_row    = r_row;

endmodule

// File: tb/tb_vga_text_buffer.sv
// Scoreboard bench for vga_text_buffer: pixel probes queue expected codes, a monitor checks zb_code.
module tb_vga_text_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        putc_valid = 1'b0;
    logic [15:0] putc_char = 16'h0000;
    logic [9:0]  xpos = 10'd0;
    logic [9:0]  ypos = 10'd0;
    logic        putc_ready, busy;
    logic [15:0] zb_code;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;

    int checks = 0;
    int failures = 0;
    int cyc;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic probe = 1'b0;
    logic probe_d = 1'b0;

    always #10 clk = ~clk;

`ifdef CURSOR_BLINK_EN
    vga_text_buffer #(.BLINK_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .putc_valid(putc_valid), .putc_ready(putc_ready),
        .putc_char(putc_char), .xpos(xpos), .ypos(ypos), .zb_code(zb_code),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );
`else
    vga_text_buffer dut (
        .clk(clk), .rst(rst), .putc_valid(putc_valid), .putc_ready(putc_ready),
        .putc_char(putc_char), .xpos(xpos), .ypos(ypos), .zb_code(zb_code),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );
`endif

    always @(posedge clk) probe_d <= probe;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: one zb_code result per probe, one clock after the pixel was applied.
    always @(negedge clk) begin
        if (probe_d) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow zb_code=%h with no expected entry", zb_code);
            end else begin
                mon_e = sb_q.pop_front();
                if (zb_code !== mon_e.exp) begin
                    failures++;
                    $display("FAIL %s zb_code=%h expected=%h", mon_e.name, zb_code, mon_e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic probe_px(input logic [9:0] x, input logic [9:0] y,
                            input logic [15:0] exp, input string name);
        exp_t t;
        t.name = name;
        t.exp  = exp;
        xpos   = x;
        ypos   = y;
        sb_q.push_back(t);
        probe  = 1'b1;
        @(negedge clk);
        probe  = 1'b0;
    endtask

    task automatic putc(input logic [15:0] ch);
        int n = 0;
        while (!putc_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!putc_ready) begin
            checks++;
            failures++;
            $display("FAIL putc_timeout ready=%0b expected=1", putc_ready);
        end else begin
            putc_valid = 1'b1;
            putc_char  = ch;
            @(negedge clk);
            putc_valid = 1'b0;
        end
    endtask

    task automatic count_busy(input int exp, input string name);
        int n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(putc_ready), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);
        chk("rst_zb", 32'(zb_code), 32'h0020);
        rst = 1'b0;
        count_busy(1000, "init_busy_cycles");
        chk("init_ready", 32'(putc_ready), 32'd1);
        probe_px(10'd16, 10'd0, 16'h0020, "init_cell_1_0");
        probe_px(10'd639, 10'd399, 16'h0020, "init_cell_last");
        probe_px(10'd320, 10'd200, 16'h0020, "init_cell_mid");

        // Three 'A's on row 0
        repeat (3) putc(16'h0041);
        chk("a3_col", 32'(cur_col), 32'd3);
        probe_px(10'd0, 10'd0, 16'h0041, "a_px0");
        probe_px(10'd47, 10'd0, 16'h0041, "a_px47");
        probe_px(10'd64, 10'd0, 16'h0020, "a_after");

        // Complete row 0, wrap, 41st char lands on row 1
        for (int c = 3; c < 40; c++) putc(16'(16'h0100 + c));
        chk("wrap_col", 32'(cur_col), 32'd0);
        chk("wrap_row", 32'(cur_row), 32'd1);
        putc(16'h0042);
        chk("c41_col", 32'(cur_col), 32'd1);
        probe_px(10'd0, 10'd16, 16'h0042, "c41_px");
        probe_px(10'd624, 10'd0, 16'h0127, "row0_col39");
        probe_px(10'd640, 10'd0, 16'h0020, "offscreen_x");
        probe_px(10'd0, 10'd400, 16'h0020, "offscreen_y");

        putc(16'h000D);
        chk("cr_col", 32'(cur_col), 32'd0);
        chk("cr_row", 32'(cur_row), 32'd1);

        // Fill rows 1..23 fully and row 24 partially, then scroll with LF
        for (int r = 1; r < 24; r++)
            for (int c = 0; c < 40; c++) putc(16'(16'h1000 + r * 64 + c));
        for (int c = 0; c < 10; c++) putc(16'(16'h1600 + c));
        chk("fill_row", 32'(cur_row), 32'd24);
        chk("fill_col", 32'(cur_col), 32'd10);
        probe_px(10'd0, 10'd384, 16'h1600, "row24_prescroll");
        putc(16'h000A);
        count_busy(40, "clear_busy_cycles");
        chk("scroll_row", 32'(cur_row), 32'd24);
        chk("scroll_col", 32'(cur_col), 32'd0);
        probe_px(10'd0, 10'd0, 16'h1040, "scroll_top_c0");
        probe_px(10'd80, 10'd0, 16'h1045, "scroll_top_c5");
        probe_px(10'd16, 10'd384, 16'h0020, "scroll_bottom_c1");
        probe_px(10'd624, 10'd384, 16'h0020, "scroll_bottom_c39");
        probe_px(10'd0, 10'd368, 16'h1600, "scroll_r23_c0");
        probe_px(10'd144, 10'd368, 16'h1609, "scroll_r23_c9");
        probe_px(10'd160, 10'd368, 16'h0020, "scroll_r23_c10");
        probe_px(10'd0, 10'd352, 16'h15C0, "scroll_r22_c0");
        putc(16'h005A);
        probe_px(10'd0, 10'd384, 16'h005A, "write_after_scroll");

        // Backspace handling
        putc(16'h0008);
        chk("bs_col1", 32'(cur_col), 32'd0);
        putc(16'h0008);
        chk("bs_col0_noop_col", 32'(cur_col), 32'd0);
        chk("bs_col0_noop_row", 32'(cur_row), 32'd24);
        for (int i = 0; i < 5; i++) putc(16'(16'h0061 + i));
        chk("bs_pre_col", 32'(cur_col), 32'd5);
        putc(16'h0008);
        chk("bs_col5", 32'(cur_col), 32'd4);
        putc(16'h000D);
        probe_px(10'd64, 10'd384, 16'h0020, "bs_cell4");
        probe_px(10'd48, 10'd384, 16'h0064, "bs_cell3");

        // Form feed
        putc(16'h000C);
        count_busy(1000, "ff_busy_cycles");
        chk("ff_col", 32'(cur_col), 32'd0);
        chk("ff_row", 32'(cur_row), 32'd0);
        probe_px(10'd16, 10'd0, 16'h0020, "ff_cell_1_0");
        probe_px(10'd0, 10'd16, 16'h0020, "ff_cell_0_1");
        probe_px(10'd624, 10'd368, 16'h0020, "ff_cell_39_23");

        // Reset in the middle of a CLEAR
        repeat (24) putc(16'h000A);
        chk("lf24_row", 32'(cur_row), 32'd24);
        putc(16'h000A);
        repeat (10) @(negedge clk);
        chk("clear_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd1);
        chk("rst_mid_ready", 32'(putc_ready), 32'd0);
        chk("rst_mid_row", 32'(cur_row), 32'd0);
        chk("rst_mid_zb", 32'(zb_code), 32'h0020);
        @(negedge clk);
        rst = 1'b0;
        count_busy(1000, "reinit_busy_cycles");
        putc(16'h0051);
        probe_px(10'd0, 10'd0, 16'h0051, "post_reset_write");
        probe_px(10'd32, 10'd0, 16'h0020, "post_reset_blank");

`ifdef CURSOR_BLINK_EN
        // Cursor sits at (1,0); blink phase follows the cycle count since reset release
        for (int i = 0; i < 20; i++)
            probe_px(10'd16, 10'd0, (((cyc / 8) % 2) == 0) ? 16'h005F : 16'h0020, "blink_cell");
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
